// File: rtl/control_unit_pipelined_if.sv
// Decode-stage control interface.
// Carries the IF/ID-side request (inst, inst_valid, stall_in, flush), the
// interlock back to IF/ID (stall_out) and the registered ID/EX control bundle.
//   master : IF/ID + ID/EX side; drives the instruction, consumes the bundle
//   slave  : control unit; consumes the instruction, drives the bundle
interface control_unit_pipelined_if #(
    parameter int unsigned INST_W     = 16,
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned ALUOP_W    = 2
);
    logic [INST_W-1:0]     inst;
    logic                  inst_valid;
    logic                  stall_in;
    logic                  flush;
    logic                  stall_out;
    logic                  ctrl_valid;
    logic                  wb_alu_to_reg;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [ALUOP_W-1:0]    alu_op;
    logic [1:0]            carry_select;
    logic [REG_ADDR_W-1:0] rd_out;
    logic [INST_W-1:0]     imm_out;
    logic                  illegal;

    modport master (
        output inst, inst_valid, stall_in, flush,
        input  stall_out, ctrl_valid, wb_alu_to_reg, reg_write, mem_read, mem_write,
        input  alu_op, carry_select, rd_out, imm_out, illegal
    );

    modport slave (
        input  inst, inst_valid, stall_in, flush,
        output stall_out, ctrl_valid, wb_alu_to_reg, reg_write, mem_read, mem_write,
        output alu_op, carry_select, rd_out, imm_out, illegal
    );
endinterface

// File: rtl/control_unit_pipelined.sv
// Decode-stage control unit.
// Decodes the IF/ID instruction into the registered ID/EX control bundle
// (1-cycle latency), with load-use interlock, flush/stall handling, illegal
// opcode flagging and an optional two-word LDM carrying a full-width immediate.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   cu   control_unit_pipelined_if.slave
//        in : inst, inst_valid, stall_in, flush
//        out: stall_out (combinational), ctrl_valid, wb_alu_to_reg, reg_write,
//             mem_read, mem_write, alu_op, carry_select, rd_out, imm_out, illegal
module control_unit_pipelined #(
    parameter int unsigned INST_W     = 16,
    parameter int unsigned OPCODE_W   = 3,
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned ALUOP_W    = 2,
    parameter int unsigned LDM_EXT    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    control_unit_pipelined_if.slave cu
);
    localparam int unsigned ImmLoW = INST_W - OPCODE_W - REG_ADDR_W;

    localparam logic [OPCODE_W-1:0] OpLdm = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OpStd = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OpAdd = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OpNot = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OpNop = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OpLdd = OPCODE_W'(6);

    localparam logic [ALUOP_W-1:0] AluAdd  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] AluNot  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] AluPass = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] AluNop  = ALUOP_W'(3);

    typedef enum logic [0:0] {StDecode, StLdmImm} state_e;

    // Instruction fields
    logic [OPCODE_W-1:0]   opcode;
    logic [REG_ADDR_W-1:0] rdst;
    logic [REG_ADDR_W-1:0] rsrc;
    logic [ImmLoW-1:0]     imm_lo;

    assign opcode = cu.inst[INST_W-1 -: OPCODE_W];
    assign rdst   = cu.inst[INST_W-OPCODE_W-1 -: REG_ADDR_W];
    assign rsrc   = cu.inst[ImmLoW-1 -: REG_ADDR_W];
    assign imm_lo = cu.inst[ImmLoW-1:0];

    // State and registered bundle
    state_e                state_q, state_d;
    logic [REG_ADDR_W-1:0] ldm_rd_q, ldm_rd_d;
    logic                  ctrl_valid_q, ctrl_valid_d;
    logic                  wb_q, wb_d;
    logic                  rw_q, rw_d;
    logic                  mr_q, mr_d;
    logic                  mw_q, mw_d;
    logic [ALUOP_W-1:0]    alu_q, alu_d;
    logic [1:0]            cs_q, cs_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [INST_W-1:0]     imm_q, imm_d;
    logic                  illegal_q, illegal_d;

    logic reads_rdst;
    logic reads_rsrc;
    logic hazard;

    always_comb begin
        // Default: bubble, hold FSM
        state_d      = state_q;
        ldm_rd_d     = ldm_rd_q;
        ctrl_valid_d = 1'b0;
        wb_d         = 1'b0;
        rw_d         = 1'b0;
        mr_d         = 1'b0;
        mw_d         = 1'b0;
        alu_d        = AluNop;
        cs_d         = 2'b00;
        rd_d         = '0;
        imm_d        = '0;
        illegal_d    = 1'b0;

        // Source registers each op reads, for the load-use compare
        reads_rdst = 1'b0;
        reads_rsrc = 1'b0;
        case (opcode)
            OpStd, OpAdd: begin
                reads_rdst = 1'b1;
                reads_rsrc = 1'b1;
            end
            OpNot:   reads_rdst = 1'b1;
            OpLdd:   reads_rsrc = 1'b1;
            default: ;
        endcase

        // A load in EX whose destination the decoding op needs: insert one bubble
        hazard = (state_q == StDecode) && cu.inst_valid && ctrl_valid_q && mr_q &&
                 ((reads_rdst && (rdst == rd_q)) || (reads_rsrc && (rsrc == rd_q)));

        if (cu.flush) begin
            // Squash; drops any pending LDM immediate
            state_d = StDecode;
        end else if (state_q == StLdmImm) begin
            // This word is the LDM immediate, not an instruction
            if (cu.inst_valid) begin
                ctrl_valid_d = 1'b1;
                rw_d         = 1'b1;
                alu_d        = AluAdd;
                rd_d         = ldm_rd_q;
                imm_d        = cu.inst;
                state_d      = StDecode;
            end
        end else if (hazard) begin
            // Bubble; IF/ID holds inst so it is re-decoded next cycle
        end else if (cu.inst_valid) begin
            case (opcode)
                OpLdm: begin
                    if (LDM_EXT != 0) begin
                        ldm_rd_d = rdst;
                        state_d  = StLdmImm;
                    end else begin
                        ctrl_valid_d = 1'b1;
                        rw_d         = 1'b1;
                        alu_d        = AluAdd;
                        rd_d         = rdst;
                        imm_d        = INST_W'(imm_lo);
                    end
                end
                OpStd: begin
                    // No register written, so rd_out stays 0
                    ctrl_valid_d = 1'b1;
                    mw_d         = 1'b1;
                    alu_d        = AluPass;
                end
                OpAdd: begin
                    ctrl_valid_d = 1'b1;
                    wb_d         = 1'b1;
                    rw_d         = 1'b1;
                    alu_d        = AluAdd;
                    cs_d         = 2'b10;
                    rd_d         = rdst;
                end
                OpNot: begin
                    ctrl_valid_d = 1'b1;
                    wb_d         = 1'b1;
                    rw_d         = 1'b1;
                    alu_d        = AluNot;
                    rd_d         = rdst;
                end
                OpNop: ctrl_valid_d = 1'b1;
                OpLdd: begin
                    ctrl_valid_d = 1'b1;
                    rw_d         = 1'b1;
                    mr_d         = 1'b1;
                    alu_d        = AluPass;
                    rd_d         = rdst;
                end
                default: illegal_d = 1'b1;
            endcase
        end
    end

    assign cu.stall_out = cu.stall_in | (hazard & ~cu.flush);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StDecode;
            ldm_rd_q     <= '0;
            ctrl_valid_q <= 1'b0;
            wb_q         <= 1'b0;
            rw_q         <= 1'b0;
            mr_q         <= 1'b0;
            mw_q         <= 1'b0;
            alu_q        <= AluNop;
            cs_q         <= 2'b00;
            rd_q         <= '0;
            imm_q        <= '0;
            illegal_q    <= 1'b0;
        end else if (!cu.stall_in) begin
            state_q      <= state_d;
            ldm_rd_q     <= ldm_rd_d;
            ctrl_valid_q <= ctrl_valid_d;
            wb_q         <= wb_d;
            rw_q         <= rw_d;
            mr_q         <= mr_d;
            mw_q         <= mw_d;
            alu_q        <= alu_d;
            cs_q         <= cs_d;
            rd_q         <= rd_d;
            imm_q        <= imm_d;
            illegal_q    <= illegal_d;
        end
    end

    assign cu.ctrl_valid    = ctrl_valid_q;
    assign cu.wb_alu_to_reg = wb_q;
    assign cu.reg_write     = rw_q;
    assign cu.mem_read      = mr_q;
    assign cu.mem_write     = mw_q;
    assign cu.alu_op        = alu_q;
    assign cu.carry_select  = cs_q;
    assign cu.rd_out        = rd_q;
    assign cu.imm_out       = imm_q;
    assign cu.illegal       = illegal_q;
endmodule

// File: tb/tb_control_unit_pipelined.sv
// Directed bench for control_unit_pipelined. dut0 runs LDM_EXT=0, dut1 LDM_EXT=1;
// both see the same input stream. Bundles are compared as packed vectors
// {ctrl_valid, wb, rw, mr, mw, alu_op, carry_select, rd_out, imm_out, illegal}.
module tb_control_unit_pipelined;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    control_unit_pipelined_if #(.INST_W(16), .REG_ADDR_W(3), .ALUOP_W(2)) if0 ();
    control_unit_pipelined_if #(.INST_W(16), .REG_ADDR_W(3), .ALUOP_W(2)) if1 ();

    control_unit_pipelined #(.LDM_EXT(0)) dut0 (.clk(clk), .rst(rst), .cu(if0));
    control_unit_pipelined #(.LDM_EXT(1)) dut1 (.clk(clk), .rst(rst), .cu(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [28:0] pk(input logic cv, input logic wb, input logic rw,
                                       input logic mr, input logic mw, input logic [1:0] alu,
                                       input logic [1:0] cs, input logic [2:0] rd,
                                       input logic [15:0] imm, input logic ill);
        return {cv, wb, rw, mr, mw, alu, cs, rd, imm, ill};
    endfunction

    function automatic logic [28:0] obs0();
        return {if0.ctrl_valid, if0.wb_alu_to_reg, if0.reg_write, if0.mem_read, if0.mem_write,
                if0.alu_op, if0.carry_select, if0.rd_out, if0.imm_out, if0.illegal};
    endfunction

    function automatic logic [28:0] obs1();
        return {if1.ctrl_valid, if1.wb_alu_to_reg, if1.reg_write, if1.mem_read, if1.mem_write,
                if1.alu_op, if1.carry_select, if1.rd_out, if1.imm_out, if1.illegal};
    endfunction

    // Expected bundles, hand-derived from the opcode table
    logic [28:0] e_bub, e_ldm1, e_std, e_add1, e_add3, e_not1, e_nop, e_ldd2, e_ill;
    logic [28:0] e_ldm_3ff, e_ldm_beef;

    task automatic set_in(input logic [15:0] i, input logic v, input logic s, input logic f);
        if0.inst = i; if0.inst_valid = v; if0.stall_in = s; if0.flush = f;
        if1.inst = i; if1.inst_valid = v; if1.stall_in = s; if1.flush = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(16'h6500, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        checks++;
        if (obs0() !== e_bub) begin
            errors++; $display("FAIL reset_bundle0: got %h expected %h", obs0(), e_bub);
        end
        checks++;
        if (obs1() !== e_bub) begin
            errors++; $display("FAIL reset_bundle1: got %h expected %h", obs1(), e_bub);
        end
        checks++;
        if (if0.stall_out !== 1'b0) begin
            errors++; $display("FAIL reset_stall_out: got %b expected 0", if0.stall_out);
        end
        rst = 1'b0;
        set_in(16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_table();
        logic [15:0] insts [6];
        logic [28:0] exps  [6];
        insts = '{16'h2400, 16'h4500, 16'h6500, 16'h8400, 16'hA000, 16'h27FF};
        exps  = '{e_ldm1, e_std, e_add1, e_not1, e_nop, e_ldm_3ff};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_in(insts[i], 1'b1, 1'b0, 1'b0);
            tick();
            checks++;
            if (obs0() !== exps[i]) begin
                errors++;
                $display("FAIL table_%h: got %h expected %h", insts[i], obs0(), exps[i]);
            end
        end
        // Not-valid input decodes to a bubble even with an opcode present
        set_in(16'h6500, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs0() !== e_bub) begin
            errors++; $display("FAIL table_invalid: got %h expected %h", obs0(), e_bub);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(16'hC880, 1'b1, 1'b0, 1'b0);   // LDD R2,[R1]
        tick();
        checks++;
        if (obs0() !== e_ldd2) begin
            errors++; $display("FAIL lu_ldd: got %h expected %h", obs0(), e_ldd2);
        end
        set_in(16'h6500, 1'b1, 1'b0, 1'b0);   // ADD R1,R2 reads R2
        #1;
        checks++;
        if (if0.stall_out !== 1'b1) begin
            errors++; $display("FAIL lu_stall_on: got %b expected 1", if0.stall_out);
        end
        tick();
        checks++;
        if (obs0() !== e_bub) begin
            errors++; $display("FAIL lu_bubble: got %h expected %h", obs0(), e_bub);
        end
        #1;
        checks++;
        if (if0.stall_out !== 1'b0) begin
            errors++; $display("FAIL lu_stall_off: got %b expected 0", if0.stall_out);
        end
        tick();
        checks++;
        if (obs0() !== e_add1) begin
            errors++; $display("FAIL lu_add: got %h expected %h", obs0(), e_add1);
        end
        // Independent registers: no interlock
        do_reset();
        set_in(16'hC880, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(16'h6E00, 1'b1, 1'b0, 1'b0);   // ADD R3,R4
        #1;
        checks++;
        if (if0.stall_out !== 1'b0) begin
            errors++; $display("FAIL lu_nostall: got %b expected 0", if0.stall_out);
        end
        tick();
        checks++;
        if (obs0() !== e_add3) begin
            errors++; $display("FAIL lu_add_indep: got %h expected %h", obs0(), e_add3);
        end
    endtask

    task automatic test_ldm_ext();
        do_reset();
        set_in(16'h2400, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (if1.stall_out !== 1'b0) begin
            errors++; $display("FAIL ldm_stall_out: got %b expected 0", if1.stall_out);
        end
        tick();
        checks++;
        if (obs1() !== e_bub) begin
            errors++; $display("FAIL ldm_first_bubble: got %h expected %h", obs1(), e_bub);
        end
        set_in(16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs1() !== e_bub) begin
            errors++; $display("FAIL ldm_wait_bubble: got %h expected %h", obs1(), e_bub);
        end
        set_in(16'hBEEF, 1'b1, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs1() !== e_ldm_beef) begin
            errors++; $display("FAIL ldm_imm: got %h expected %h", obs1(), e_ldm_beef);
        end
        set_in(16'h6500, 1'b1, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs1() !== e_add1) begin
            errors++; $display("FAIL ldm_back_decode: got %h expected %h", obs1(), e_add1);
        end
    endtask

    task automatic test_flush();
        do_reset();
        set_in(16'h2400, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(16'hBEEF, 1'b1, 1'b0, 1'b1);
        tick();
        checks++;
        if (obs1() !== e_bub) begin
            errors++; $display("FAIL flush_ldm_imm: got %h expected %h", obs1(), e_bub);
        end
        set_in(16'h6500, 1'b1, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs1() !== e_add1) begin
            errors++; $display("FAIL flush_decode: got %h expected %h", obs1(), e_add1);
        end
        set_in(16'h8400, 1'b1, 1'b0, 1'b1);
        tick();
        checks++;
        if (obs0() !== e_bub) begin
            errors++; $display("FAIL flush_squash: got %h expected %h", obs0(), e_bub);
        end
    endtask

    task automatic test_stall();
        do_reset();
        set_in(16'h6500, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(16'h8400, 1'b1, 1'b1, 1'b0);
            #1;
            checks++;
            if (if0.stall_out !== 1'b1) begin
                errors++; $display("FAIL stall_out_%0d: got %b expected 1", i, if0.stall_out);
            end
            tick();
            checks++;
            if (obs0() !== e_add1) begin
                errors++; $display("FAIL stall_hold_%0d: got %h expected %h", i, obs0(), e_add1);
            end
        end
        set_in(16'h8400, 1'b1, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs0() !== e_not1) begin
            errors++; $display("FAIL stall_release: got %h expected %h", obs0(), e_not1);
        end
    endtask

    task automatic test_illegal();
        logic [15:0] ops [2];
        ops = '{16'hE000, 16'h0000};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(ops[i], 1'b1, 1'b0, 1'b0);
            tick();
            checks++;
            if (obs0() !== e_ill) begin
                errors++; $display("FAIL illegal_%h: got %h expected %h", ops[i], obs0(), e_ill);
            end
            set_in(16'h0000, 1'b0, 1'b0, 1'b0);
            tick();
            checks++;
            if (obs0() !== e_bub) begin
                errors++; $display("FAIL illegal_pulse_%h: got %h expected %h", ops[i], obs0(),
                                   e_bub);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        set_in(16'h0000, 1'b0, 1'b0, 1'b0);
        e_bub      = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 3'd0, 16'h0000, 1'b0);
        e_ldm1     = pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 3'd1, 16'h0000, 1'b0);
        e_ldm_3ff  = pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 3'd1, 16'h03FF, 1'b0);
        e_ldm_beef = pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 3'd1, 16'hBEEF, 1'b0);
        e_std      = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 3'd0, 16'h0000, 1'b0);
        e_add1     = pk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 3'd1, 16'h0000, 1'b0);
        e_add3     = pk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 3'd3, 16'h0000, 1'b0);
        e_not1     = pk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 3'd1, 16'h0000, 1'b0);
        e_nop      = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 3'd0, 16'h0000, 1'b0);
        e_ldd2     = pk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 3'd2, 16'h0000, 1'b0);
        e_ill      = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 3'd0, 16'h0000, 1'b1);

        test_reset();
        test_table();
        test_load_use();
        test_ldm_ext();
        test_flush();
        test_stall();
        test_illegal();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
